// File: rtl/ntt_bf_addsub.sv
// NTT butterfly back end: delays u alongside mo_mul, forms (u+t) and (u-t) mod Q,
// and buffers results in an output FIFO guarded by a credit-based in_ready.
module ntt_bf_addsub #(
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329,
    parameter int MUL_DELAY  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             u,
    input  logic [DATA_WIDTH:0]               t,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_add,
    output logic [DATA_WIDTH-1:0]             out_sub,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + MUL_DELAY + 2) + 1;
    localparam logic signed [DW+1:0] QS = (DW+2)'(Q);

    if (FIFO_DEPTH < MUL_DELAY + 3) begin : g_depth_chk
        $error("ntt_bf_addsub: FIFO_DEPTH must be >= MUL_DELAY+3");
    end

    logic                   en_q;
    logic [MUL_DELAY-1:0]   vld_q;
    logic [DW-1:0]          ud_q [MUL_DELAY];
    logic                   s1_vld_q;
    logic signed [DW+1:0]   s_q, d_q;
    logic signed [DW+1:0]   s_d, d_d;
    logic [DW-1:0]          res_add, res_sub;
    logic [DW-1:0]          mem_add [FIFO_DEPTH];
    logic [DW-1:0]          mem_sub [FIFO_DEPTH];
    logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DW-1:0]          out_add_q, out_add_d, out_sub_q, out_sub_d;
    logic [OW-1:0]          occ;
    logic                   xfer, push, pop;

    function automatic logic [DW-1:0] fold(input logic signed [DW+1:0] x);
        if (x < 0)        return DW'(x + QS);
        else if (x >= QS) return DW'(x - QS);
        else              return DW'(x);
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign xfer      = in_valid & in_ready;
    assign push      = s1_vld_q;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = en_q & (occ < OW'(FIFO_DEPTH));
    assign out_add   = out_add_q;
    assign out_sub   = out_sub_q;
    assign fifo_cnt  = cnt_q;

    // Credit: everything already accepted, whether buffered or still in flight.
    always_comb begin
        occ = OW'(cnt_q) + OW'(s1_vld_q);
        for (int i = 0; i < MUL_DELAY; i++) occ = occ + OW'(vld_q[i]);
    end

    // Stage-1 sum/difference in signed DW+2 bits, ranges (-Q, 2Q).
    always_comb begin
        s_d = $signed({2'b00, ud_q[MUL_DELAY-1]}) + $signed({t[DW], t});
        d_d = $signed({2'b00, ud_q[MUL_DELAY-1]}) - $signed({t[DW], t});
    end

    // Stage-2 single conditional correction into [0, Q).
    always_comb begin
        res_add = fold(s_q);
        res_sub = fold(d_q);
    end

    // FIFO pointer/count update and next registered head value.
    always_comb begin
        rd_d      = pop  ? inc(rd_q) : rd_q;
        wr_d      = push ? inc(wr_q) : wr_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        out_add_d = out_add_q;
        out_sub_d = out_sub_q;
        if (cnt_q == CW'(pop)) begin
            if (push) begin
                out_add_d = res_add;
                out_sub_d = res_sub;
            end
        end else begin
            out_add_d = mem_add[rd_d];
            out_sub_d = mem_sub[rd_d];
        end
    end

    // Delay line tracking mo_mul, then the stage-1 register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            vld_q    <= '0;
            for (int i = 0; i < MUL_DELAY; i++) ud_q[i] <= '0;
            s1_vld_q <= 1'b0;
            s_q      <= '0;
            d_q      <= '0;
        end else begin
            en_q     <= 1'b1;
            vld_q[0] <= xfer;
            ud_q[0]  <= u;
            for (int i = 1; i < MUL_DELAY; i++) begin
                vld_q[i] <= vld_q[i-1];
                ud_q[i]  <= ud_q[i-1];
            end
            s1_vld_q <= vld_q[MUL_DELAY-1];
            if (vld_q[MUL_DELAY-1]) begin
                s_q <= s_d;
                d_q <= d_d;
            end
        end
    end

    // FIFO control state and registered head outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            out_add_q <= '0;
            out_sub_q <= '0;
        end else begin
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            out_add_q <= out_add_d;
            out_sub_q <= out_sub_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_add[wr_q] <= res_add;
            mem_sub[wr_q] <= res_sub;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ntt_bf_addsub.sv
// Directed and scoreboarded bench for ntt_bf_addsub (Q=3329, MUL_DELAY=4, depth 8).
// Drives t from a local model of the mo_mul delay; stray t values are garbage.
module tb_ntt_bf_addsub;

    localparam int DW = 12;
    localparam int Q  = 3329;
    localparam int MD = 4;
    localparam int FD = 8;
    localparam int CW = $clog2(FD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] u;
    logic [DW:0]   t;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_add, out_sub;
    logic [CW-1:0] fifo_cnt;

    int checks = 0;
    int errors = 0;
    int nxfer  = 0;
    int exp_add[$], exp_sub[$], got_add[$], got_sub[$];
    logic [DW:0] tq [MD];

    ntt_bf_addsub #(.DATA_WIDTH(DW), .Q(Q), .MUL_DELAY(MD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .u(u), .t(t), .out_valid(out_valid), .out_ready(out_ready),
        .out_add(out_add), .out_sub(out_sub), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    function automatic int mod_q(input int x);
        int r;
        r = x % Q;
        if (r < 0) r = r + Q;
        return r;
    endfunction

    function automatic int rand_t();
        return int'($urandom_range(2 * Q - 2)) - (Q - 1);
    endfunction

    // One clock cycle: drive inputs, log transfers/pops, advance to edge+1.
    task automatic step(input bit v, input int uu, input int tt, input bit ordy);
        bit x, p;
        in_valid  = v;
        u         = DW'(uu);
        out_ready = ordy;
        t         = tq[MD-1];
        x = v & in_ready;
        p = out_valid & ordy;
        if (p) begin
            got_add.push_back(int'(out_add));
            got_sub.push_back(int'(out_sub));
        end
        if (x) begin
            exp_add.push_back(mod_q(uu + tt));
            exp_sub.push_back(mod_q(uu - tt));
            nxfer++;
        end
        for (int i = MD - 1; i > 0; i--) tq[i] = tq[i-1];
        tq[0] = x ? (DW+1)'(tt) : 13'h0aaa;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_add.delete(); exp_sub.delete();
        got_add.delete(); got_sub.delete();
        nxfer = 0;
    endtask

    task automatic drain();
        repeat (30) step(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; u = '0; t = '0;
        for (int i = 0; i < MD; i++) tq[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL rst_fifo_cnt got %0d exp 0", fifo_cnt); end
        checks++; if (out_add !== 12'd0 || out_sub !== 12'd0) begin
            errors++; $display("FAIL rst_outputs got %0d/%0d exp 0/0", out_add, out_sub);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        int vu[4] = '{5, 3328, 0, 0};
        int vt[4] = '{-7, 3328, -3328, 0};
        int ea[4] = '{3327, 3327, 1, 0};
        int es[4] = '{12, 0, 3328, 0};
        int n;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            step(1, vu[i], vt[i], 1);
            n = 1;
            while (out_valid !== 1'b1 && n < 20) begin
                step(0, 0, 0, 1);
                n++;
            end
            checks++; if (n != 6) begin errors++; $display("FAIL dir_latency[%0d] got %0d exp 6", i, n); end
            checks++; if (out_add !== DW'(ea[i]) || out_sub !== DW'(es[i])) begin
                errors++;
                $display("FAIL dir_value[%0d] got %0d/%0d exp %0d/%0d", i, out_add, out_sub, ea[i], es[i]);
            end
        end
        drain();
        clear_q();
    endtask

    task automatic test_sweep();
        clear_q();
        for (int k = 0; k < Q; k++) step(1, k, rand_t(), 1);
        checks++; if (nxfer != Q) begin errors++; $display("FAIL sweep_xfers got %0d exp %0d", nxfer, Q); end
        drain();
        checks++; if (got_add.size() != exp_add.size()) begin
            errors++; $display("FAIL sweep_count got %0d exp %0d", got_add.size(), exp_add.size());
        end
        for (int i = 0; i < got_add.size() && i < exp_add.size(); i++) begin
            checks++;
            if (got_add[i] != exp_add[i] || got_sub[i] != exp_sub[i]) begin
                errors++;
                $display("FAIL sweep_data[%0d] got %0d/%0d exp %0d/%0d",
                         i, got_add[i], got_sub[i], exp_add[i], exp_sub[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        clear_q();
        repeat (20) step(1, int'($urandom_range(Q - 1)), rand_t(), 0);
        checks++; if (nxfer != FD) begin errors++; $display("FAIL bp_xfers got %0d exp %0d", nxfer, FD); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL bp_fifo_cnt got %0d exp 8", fifo_cnt); end
        step(0, 0, 0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
        drain();
        checks++; if (got_add.size() != FD) begin
            errors++; $display("FAIL bp_count got %0d exp %0d", got_add.size(), FD);
        end
        for (int i = 0; i < got_add.size() && i < exp_add.size(); i++) begin
            checks++;
            if (got_add[i] != exp_add[i] || got_sub[i] != exp_sub[i]) begin
                errors++;
                $display("FAIL bp_data[%0d] got %0d/%0d exp %0d/%0d",
                         i, got_add[i], got_sub[i], exp_add[i], exp_sub[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int gaps;
        clear_q();
        gaps = 0;
        for (int i = 1; i <= 1000; i++) begin
            step(1, int'($urandom_range(Q - 1)), rand_t(), 1);
            if (i >= 6 && out_valid !== 1'b1) gaps++;
        end
        checks++; if (nxfer != 1000) begin errors++; $display("FAIL b2b_xfers got %0d exp 1000", nxfer); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps got %0d exp 0", gaps); end
        drain();
        checks++; if (got_add.size() != exp_add.size()) begin
            errors++; $display("FAIL b2b_count got %0d exp %0d", got_add.size(), exp_add.size());
        end
        for (int i = 0; i < got_add.size() && i < exp_add.size(); i++) begin
            checks++;
            if (got_add[i] != exp_add[i] || got_sub[i] != exp_sub[i]) begin
                errors++;
                $display("FAIL b2b_data[%0d] got %0d/%0d exp %0d/%0d",
                         i, got_add[i], got_sub[i], exp_add[i], exp_sub[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_random();
        int over, oor;
        clear_q();
        over = 0;
        oor  = 0;
        repeat (800) begin
            step(bit'($urandom_range(1)), int'($urandom_range(Q - 1)), rand_t(), bit'($urandom_range(1)));
            if (fifo_cnt > 4'd8) over++;
            if (out_valid && (out_add >= 12'(Q) || out_sub >= 12'(Q))) oor++;
        end
        checks++; if (over != 0) begin errors++; $display("FAIL rnd_fifo_cnt over8 got %0d exp 0", over); end
        checks++; if (oor != 0) begin errors++; $display("FAIL rnd_range got %0d exp 0", oor); end
        drain();
        checks++; if (got_add.size() != exp_add.size()) begin
            errors++; $display("FAIL rnd_count got %0d exp %0d", got_add.size(), exp_add.size());
        end
        for (int i = 0; i < got_add.size() && i < exp_add.size(); i++) begin
            checks++;
            if (got_add[i] != exp_add[i] || got_sub[i] != exp_sub[i]) begin
                errors++;
                $display("FAIL rnd_data[%0d] got %0d/%0d exp %0d/%0d",
                         i, got_add[i], got_sub[i], exp_add[i], exp_sub[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int n;
        clear_q();
        repeat (5) step(1, int'($urandom_range(Q - 1)), rand_t(), 0);
        n = 0;
        while (fifo_cnt !== 4'd5 && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        checks++; if (fifo_cnt !== 4'd5) begin errors++; $display("FAIL mid_fill got %0d exp 5", fifo_cnt); end
        repeat (3) step(1, int'($urandom_range(Q - 1)), rand_t(), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL mid_fifo_cnt got %0d exp 0", fifo_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b exp 0", in_ready); end
        checks++; if (out_add !== 12'd0) begin errors++; $display("FAIL mid_out_add got %0d exp 0", out_add); end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < MD; i++) tq[i] = '0;
        rst = 1'b1;
        clear_q();
        repeat (20) step(0, 0, 0, 1);
        checks++; if (got_add.size() != 0) begin
            errors++; $display("FAIL mid_stale got %0d pops exp 0", got_add.size());
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b exp 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
